// File: rtl/mul_wb_queue_pkg.sv
// Shared defines and entry layout for the multiply write-back queue.
// The M stages and decode use the same field macros, so flag positions stay consistent.
`ifndef MUL_WB_QUEUE_DEFS
`define MUL_WB_QUEUE_DEFS
`ifndef REG_SIZE
`define REG_SIZE 32
`endif
`define MUL_WB_DEPTH 4
// Entry layout, LSB first: dst[4:0], overflow, zero, result
`define MUL_WB_DST_LSB 0
`define MUL_WB_OVF_BIT 5
`define MUL_WB_ZERO_BIT 6
`define MUL_WB_RES_LSB 7
`define MUL_WB_ENTRY_W (`REG_SIZE + 7)
`endif

package mul_wb_queue_pkg;
   localparam int REG_SIZE = `REG_SIZE;
   localparam int ENTRY_W  = `MUL_WB_ENTRY_W;

   typedef struct packed {
      logic [REG_SIZE-1:0] result;
      logic                zero;
      logic                overflow;
      logic [4:0]          dst;
   } mul_wb_entry_t;

   function automatic mul_wb_entry_t pack_entry(input logic [REG_SIZE-1:0] result,
                                                input logic zero, input logic ovf,
                                                input logic [4:0] dst);
      logic [ENTRY_W-1:0] raw;
      raw                              = '0;
      raw[`MUL_WB_RES_LSB +: REG_SIZE] = result;
      raw[`MUL_WB_ZERO_BIT]            = zero;
      raw[`MUL_WB_OVF_BIT]             = ovf;
      raw[`MUL_WB_DST_LSB +: 5]        = dst;
      return mul_wb_entry_t'(raw);
   endfunction
endpackage

// File: rtl/mul_wb_queue_if.sv
// Bus between the last M stage / decode / register file and the write-back queue.
interface mul_wb_if;
   import mul_wb_queue_pkg::*;
   logic                m_valid;
   logic [REG_SIZE-1:0] m_result;
   logic                m_zero;
   logic                m_overflow;
   logic [4:0]          m_dst;
   logic                wb_busy;
   logic                wb_we;
   logic [REG_SIZE-1:0] wb_data;
   logic [4:0]          wb_dst;
   logic                wb_zero;
   logic                ovf_exc;
   logic                mul_stall;
   logic [4:0]          fwd_addr;
   logic                fwd_hit;
   logic [REG_SIZE-1:0] fwd_data;
   logic                drop_err;

   modport slave (
      input  m_valid, m_result, m_zero, m_overflow, m_dst, wb_busy, fwd_addr,
      output wb_we, wb_data, wb_dst, wb_zero, ovf_exc, mul_stall, fwd_hit, fwd_data, drop_err
   );
   modport master (
      output m_valid, m_result, m_zero, m_overflow, m_dst, wb_busy, fwd_addr,
      input  wb_we, wb_data, wb_dst, wb_zero, ovf_exc, mul_stall, fwd_hit, fwd_data, drop_err
   );
endinterface

// File: rtl/mul_wb_queue_fwd_scan.sv
// Youngest-first match of decode's source register against the queued entries.
module mul_wb_fwd_scan
   import mul_wb_queue_pkg::*;
#(
   parameter int DEPTH = `MUL_WB_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  mul_wb_entry_t [DEPTH-1:0] ent,
   input  logic [DEPTH-1:0]          vld,
   input  logic [PTR_W-1:0]          wr_ptr,
   input  logic [4:0]                fwd_addr,
   output logic                      hit,
   output logic [REG_SIZE-1:0]       data
);
   logic [DEPTH-1:0] match;

   // Overflowed results are never written, so they must never be forwarded.
   for (genvar i = 0; i < DEPTH; i++) begin : g_match
      assign match[i] = vld[i] && !ent[i].overflow && (ent[i].dst == fwd_addr) && (fwd_addr != 5'd0);
   end

   // Walk oldest to youngest (wr_ptr-DEPTH .. wr_ptr-1); the last match wins.
   always_comb begin
      logic [PTR_W-1:0] idx;
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int a = DEPTH; a >= 1; a--) begin
         idx = wr_ptr - PTR_W'(a);
         if (match[idx]) begin
            hit  = 1'b1;
            data = ent[idx].result;
         end
      end
   end
endmodule

// File: rtl/mul_wb_queue.sv
// In-order queue between the last multiply stage and the shared register-file write port.
// Drains whenever the integer pipeline leaves the port free; forwards queued results to decode.
module mul_wb_queue
   import mul_wb_queue_pkg::*;
#(
   parameter int DEPTH     = `MUL_WB_DEPTH,  // power of two, >= 2
   parameter int STALL_LVL = 2
) (
   input  logic      clk,
   input  logic      reset_n,
   mul_wb_if.slave   bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   mul_wb_entry_t [DEPTH-1:0] mem;
   logic [DEPTH-1:0]          vld, vld_nxt;
   logic [PTR_W-1:0]          wr_ptr, rd_ptr;
   logic [CNT_W-1:0]          count;
   logic                      drop_err_q;

   mul_wb_entry_t head, in_ent;
   logic          full, nonempty, keep, push, pop, drop;

   assign head     = mem[rd_ptr];
   assign in_ent   = pack_entry(bus.m_result, bus.m_zero, bus.m_overflow, bus.m_dst);
   assign full     = (count == CNT_W'(DEPTH));
   assign nonempty = (count != '0);
   // r0 writes are no-ops, but an overflow to r0 still has to raise its exception.
   assign keep     = bus.m_valid && ((bus.m_dst != 5'd0) || bus.m_overflow);
   assign pop      = nonempty && !bus.wb_busy;
   assign push     = keep && (!full || pop);
   assign drop     = keep && full && !pop;

   always_comb begin
      vld_nxt = vld;
      if (pop)  vld_nxt[rd_ptr] = 1'b0;
      if (push) vld_nxt[wr_ptr] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_ent;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         vld        <= '0;
         drop_err_q <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
         vld   <= vld_nxt;
         if (drop) drop_err_q <= 1'b1;
      end
   end

   assign bus.wb_we     = pop && !head.overflow;
   assign bus.ovf_exc   = pop && head.overflow;
   assign bus.wb_data   = nonempty ? head.result : '0;
   assign bus.wb_dst    = nonempty ? head.dst    : 5'd0;
   assign bus.wb_zero   = nonempty && head.zero;
   assign bus.mul_stall = (count >= CNT_W'(STALL_LVL));
   assign bus.drop_err  = drop_err_q;

   mul_wb_fwd_scan #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd (
      .ent      (mem),
      .vld      (vld),
      .wr_ptr   (wr_ptr),
      .fwd_addr (bus.fwd_addr),
      .hit      (bus.fwd_hit),
      .data     (bus.fwd_data)
   );
endmodule

// File: tb/tb_mul_wb_queue.sv
// Randomized and directed checks of mul_wb_queue against a queue-based reference model.
module tb_mul_wb_queue;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   mul_wb_if bus();

   mul_wb_queue #(.DEPTH(4), .STALL_LVL(2)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      logic [31:0] res;
      bit          zero;
      bit          ovf;
      logic [4:0]  dst;
   } ent_t;

   ent_t mq[$];
   bit   drop_m = 1'b0;
   int   vecs = 0;
   int   miscmp = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         miscmp++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive_idle();
      bus.m_valid    = 1'b0;
      bus.m_result   = '0;
      bus.m_zero     = 1'b0;
      bus.m_overflow = 1'b0;
      bus.m_dst      = '0;
      bus.wb_busy    = 1'b0;
      bus.fwd_addr   = '0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_we"},    32'(bus.wb_we), 0);
      chk({tag, "_ovf"},   32'(bus.ovf_exc), 0);
      chk({tag, "_data"},  bus.wb_data, 0);
      chk({tag, "_dst"},   32'(bus.wb_dst), 0);
      chk({tag, "_zero"},  32'(bus.wb_zero), 0);
      chk({tag, "_stall"}, 32'(bus.mul_stall), 0);
      chk({tag, "_hit"},   32'(bus.fwd_hit), 0);
      chk({tag, "_fdata"}, bus.fwd_data, 0);
      chk({tag, "_drop"},  32'(bus.drop_err), 0);
   endtask

   // One clock: drive at negedge, compare against the model, then advance the model at posedge.
   task automatic step(input bit v, input logic [31:0] r, input bit z, input bit o,
                       input logic [4:0] d, input bit busy, input logic [4:0] fa);
      int          n;
      bit          pop, hit;
      logic [31:0] fd;
      ent_t        e;
      @(negedge clk);
      bus.m_valid = v; bus.m_result = r; bus.m_zero = z; bus.m_overflow = o;
      bus.m_dst = d; bus.wb_busy = busy; bus.fwd_addr = fa;
      #1;
      n   = mq.size();
      pop = (n != 0) && !busy;
      hit = 1'b0;
      fd  = '0;
      foreach (mq[i])
         if (!mq[i].ovf && mq[i].dst == fa && fa != 5'd0) begin
            hit = 1'b1;
            fd  = mq[i].res;
         end
      chk("wb_we",    32'(bus.wb_we),     32'(pop && !mq[0].ovf));
      chk("ovf_exc",  32'(bus.ovf_exc),   32'(pop && mq[0].ovf));
      chk("wb_data",  bus.wb_data,        n != 0 ? mq[0].res : 32'd0);
      chk("wb_dst",   32'(bus.wb_dst),    n != 0 ? 32'(mq[0].dst) : 32'd0);
      chk("wb_zero",  32'(bus.wb_zero),   n != 0 ? 32'(mq[0].zero) : 32'd0);
      chk("stall",    32'(bus.mul_stall), 32'(n >= 2));
      chk("fwd_hit",  32'(bus.fwd_hit),   32'(hit));
      chk("fwd_data", bus.fwd_data,       fd);
      chk("drop_err", 32'(bus.drop_err),  32'(drop_m));
      @(posedge clk);
      if (pop) void'(mq.pop_front());
      if (v && (d != 5'd0 || o)) begin
         if (n < 4 || pop) begin
            e.res = r; e.zero = z; e.ovf = o; e.dst = d;
            mq.push_back(e);
         end else drop_m = 1'b1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive_idle();
      reset_n = 1'b0;
      #1;
      chk_zero("rst");
      mq.delete();
      drop_m = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      int busy_pct;
      bit honour;
      drive_idle();
      #1;
      chk_zero("por");
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      // single push, 1-cycle latency
      step(1, 32'h6, 0, 0, 5, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);

      // busy fill, stall, forward, in-order retire
      for (int i = 1; i <= 4; i++) step(1, 32'(i), i[0], 0, 5'(i), 1, 3);
      repeat (2) step(0, 0, 0, 0, 0, 1, 3);
      repeat (5) step(0, 0, 0, 0, 0, 0, 3);

      // full + busy push drops; full + pop push is accepted
      for (int i = 1; i <= 4; i++) step(1, 32'(i * 11), 0, 0, 5'(i), 1, 0);
      step(1, 32'h77, 0, 0, 7, 1, 7);
      step(0, 0, 0, 0, 0, 1, 7);
      do_reset();
      for (int i = 1; i <= 4; i++) step(1, 32'(i * 11), 0, 0, 5'(i), 1, 0);
      step(1, 32'h77, 0, 0, 7, 0, 7);
      repeat (5) step(0, 0, 0, 0, 0, 0, 7);

      // overflow retires as exception only; r0 writes vanish
      step(1, 32'h55, 0, 1, 9, 0, 9);
      step(0, 0, 0, 0, 0, 0, 9);
      step(0, 0, 0, 0, 0, 0, 9);
      step(1, 32'h123, 0, 0, 0, 0, 0);
      step(1, 32'h321, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);

      // youngest match wins, including while the older one pops
      step(1, 32'd10, 0, 0, 4, 1, 4);
      step(1, 32'd20, 0, 0, 4, 1, 4);
      step(0, 0, 0, 0, 0, 1, 4);
      repeat (3) step(0, 0, 0, 0, 0, 0, 4);

      // asynchronous reset mid-cycle with 3 entries queued
      for (int i = 1; i <= 3; i++) step(1, 32'(i + 100), 0, 0, 5'(i), 1, 2);
      @(negedge clk);
      bus.m_valid = 1'b0; bus.wb_busy = 1'b0; bus.fwd_addr = 5'd2;
      #3;
      reset_n = 1'b0;
      #1;
      chk_zero("async_rst");
      mq.delete();
      drop_m = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) step(0, 0, 0, 0, 0, 0, 2);

      // randomized phases with varying back-pressure
      busy_pct = 0;
      honour = 1'b1;
      for (int c = 0; c < 600; c++) begin
         if (c % 60 == 0) begin
            busy_pct = $urandom_range(0, 90);
            honour   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) do_reset();
         end
         step(($urandom_range(0, 9) < 6) && (!honour || mq.size() < 2),
              $urandom, $urandom_range(0, 1), $urandom_range(0, 7) == 0,
              5'($urandom_range(0, 7)), $urandom_range(0, 99) < busy_pct,
              5'($urandom_range(0, 7)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
      $finish;
   end
endmodule
